serial_result_rx: RTL and testbench

- Receiving end of the calculator's serial result link.
- Deserialises the D_OUT / CLK_Tx / D_OUT_VALID stream produced by the calculator's transmit path into parallel words.
- Presents each completed word through a valid/ready holding register and flags framing and overrun faults.
- Sits between the calculator's serial output and any downstream checker or host-side consumer.

---
 rtl/serial_result_rx.sv | 138 +++++++++++++
 tb/tb_serial_result_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_result_rx.sv
// Deserialises the calculator's CLK_Tx / D_OUT / D_OUT_VALID result stream into words behind a valid/ready register.
// Define SERIAL_RX_PARITY_EN to expect a trailing even-parity bit after the WIDTH data bits.
`timescale 1ns/1ps
module serial_result_rx #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLK_Tx,
  input  logic             D_OUT_VALID,
  input  logic             D_OUT,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  input  logic             RX_READY,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  output logic             PARITY_ERR
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t           state_q;
  logic             tx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic             done_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_bad_q;
  logic             par_err_q;
`endif

  logic sample;
  logic take_bit;
  logic last_bit;

  // CLK_Tx is derived from CLK, so a single delay flop suffices for edge detection.
  assign sample   = tx_q & ~CLK_Tx;
  assign take_bit = sample & D_OUT_VALID;
  assign last_bit = (cnt_q == LAST_CNT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      tx_q        <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      tx_q        <= CLK_Tx;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif

      case (state_q)
        IDLE, SHIFT: begin
          if (state_q == SHIFT && !D_OUT_VALID) begin
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else if (take_bit) begin
            if (cnt_q < DATA_CNT) sr_q <= {sr_q[WIDTH-2:0], D_OUT};
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= last_bit ? DRAIN : SHIFT;
            done_q  <= last_bit;
`ifdef SERIAL_RX_PARITY_EN
            // Only consumed alongside done_q, i.e. when D_OUT is the parity bit.
            par_bad_q <= (^sr_q) ^ D_OUT;
`endif
          end
        end
        DRAIN: begin
          if (!D_OUT_VALID) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (rx_valid_q && RX_READY) rx_valid_q <= 1'b0;

      // Completion is handled one CLK after the final sample; a same-edge accept frees the slot.
      if (done_q) begin
`ifdef SERIAL_RX_PARITY_EN
        if (par_bad_q) begin
          par_err_q <= 1'b1;
        end else if (!rx_valid_q || RX_READY) begin
          rx_data_q  <= sr_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
`else
        if (!rx_valid_q || RX_READY) begin
          rx_data_q  <= sr_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  assign PARITY_ERR = par_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_result_rx.sv
// Directed bench for serial_result_rx: a scoreboard queue holds expected words, popped at each RX handshake.
`timescale 1ns/1ps
module tb_serial_result_rx;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_tx = 1'b0;
  logic             dv = 1'b0;
  logic             dout = 1'b0;
  logic             rx_ready = 1'b0;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
`ifdef SERIAL_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_result_rx #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .CLK_Tx     (clk_tx),
    .D_OUT_VALID(dv),
    .D_OUT      (dout),
    .RX_DATA    (rx_data),
    .RX_VALID   (rx_valid),
    .RX_READY   (rx_ready),
    .FRAME_ERR  (frame_err),
    .OVERRUN    (overrun),
    .PARITY_ERR (parity_err)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives nbits MSB-first; returns on the negedge after the last sampling edge (plus half-1 cycles).
  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      clk_tx = 1'b1;
      dout   = w[WIDTH-1-i];
      dv     = 1'b1;
      repeat (half) @(negedge clk);
      clk_tx = 1'b0;
      repeat (half) @(negedge clk);
    end
`ifdef SERIAL_RX_PARITY_EN
    if (nbits == WIDTH) begin
      clk_tx = 1'b1;
      dout   = (^w) ^ bad_par;
      repeat (half) @(negedge clk);
      clk_tx = 1'b0;
      repeat (half) @(negedge clk);
    end
`endif
  endtask

  task automatic end_frame();
    dv   = 1'b0;
    dout = 1'b0;
    @(negedge clk);
  endtask

  // Each cycle in which a word sits with READY high, it is accepted on the next edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", WIDTH'(rx_valid), '0);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("sb_word", rx_data, e);
        $display("accept word %h (expected %h)", rx_data, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", WIDTH'(rx_valid), '0);
    check("rst_data", rx_data, '0);
    check("rst_frame_err", WIDTH'(frame_err), '0);
    check("rst_overrun", WIDTH'(overrun), '0);
    check("rst_parity_err", WIDTH'(parity_err), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // First frame at CLK/2, consumer not ready; check the one-CLK completion latency.
    exp_q.push_back(32'h0A070011);
    send_bits(32'h0A070011, WIDTH, 1);
    check("s1_valid_before_latency", WIDTH'(rx_valid), '0);
    end_frame();
    check("s1_valid", WIDTH'(rx_valid), 1);
    check("s1_data", rx_data, 32'h0A070011);
    check("s1_frame_err", WIDTH'(frame_err), '0);
    check("s1_overrun", WIDTH'(overrun), '0);

    // Second frame while the first is unconsumed: dropped with OVERRUN.
    send_bits(32'h1C040307, WIDTH, 1);
    end_frame();
    check("s2_overrun", WIDTH'(overrun), 1);
    check("s2_data_held", rx_data, 32'h0A070011);
    check("s2_valid_held", WIDTH'(rx_valid), 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("s2_valid_cleared", WIDTH'(rx_valid), '0);

    // Frame truncated after 12 bits.
    rx_ready = 1'b1;
    send_bits(32'hA5A00000, 12, 1);
    check("s3_no_err_yet", WIDTH'(frame_err), '0);
    dv = 1'b0;
    @(negedge clk);
    check("s3_frame_err_pulse", WIDTH'(frame_err), 1);
    @(negedge clk);
    check("s3_frame_err_single", WIDTH'(frame_err), '0);
    check("s3_valid_low", WIDTH'(rx_valid), '0);
    exp_q.push_back(32'hFFFFFFFF);
    send_bits(32'hFFFFFFFF, WIDTH, 1);
    end_frame();
    check("s3_recover_data", rx_data, 32'hFFFFFFFF);
    @(negedge clk);

    // Asynchronous reset in the middle of bit 20.
    check("s5_pre_overrun", WIDTH'(overrun), 1);
    send_bits(32'hDEADBEEF, 20, 1);
    rst_n = 1'b0;
    #1;
    check("s5_async_data", rx_data, '0);
    check("s5_async_valid", WIDTH'(rx_valid), '0);
    check("s5_async_overrun", WIDTH'(overrun), '0);
    check("s5_async_frame_err", WIDTH'(frame_err), '0);
    check("s5_async_parity_err", WIDTH'(parity_err), '0);
    dv = 1'b0;
    clk_tx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s5_no_err_after_reset", WIDTH'(frame_err), '0);
    exp_q.push_back(32'h12345678);
    send_bits(32'h12345678, WIDTH, 1);
    end_frame();
    check("s5_data", rx_data, 32'h12345678);
    @(negedge clk);

    // Back-to-back frames at CLK/4 with the consumer always ready.
    exp_q.push_back(32'h00000001);
    send_bits(32'h00000001, WIDTH, 2);
    end_frame();
    exp_q.push_back(32'h80000000);
    send_bits(32'h80000000, WIDTH, 2);
    end_frame();
    @(negedge clk);
    check("s4_no_overrun", WIDTH'(overrun), '0);
    check("s4_last_data", rx_data, 32'h80000000);
    check("s4_valid_drained", WIDTH'(rx_valid), '0);

    // Completion on the same edge as the acceptance of the held word.
    rx_ready = 1'b0;
    exp_q.push_back(32'h5A5AA5A5);
    send_bits(32'h5A5AA5A5, WIDTH, 1);
    end_frame();
    exp_q.push_back(32'h3C3CC3C3);
    send_bits(32'h3C3CC3C3, WIDTH, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("coinc_valid_stays", WIDTH'(rx_valid), 1);
    check("coinc_new_data", rx_data, 32'h3C3CC3C3);
    check("coinc_no_overrun", WIDTH'(overrun), '0);
    end_frame();
    @(negedge clk);

`ifdef SERIAL_RX_PARITY_EN
    // 0x0A070011 has seven ones, so the even-parity bit is 1; the flipped bit must be rejected.
    bad_par = 1'b1;
    send_bits(32'h0A070011, WIDTH, 1);
    end_frame();
    check("par_err_pulse", WIDTH'(parity_err), 1);
    check("par_no_valid", WIDTH'(rx_valid), '0);
    @(negedge clk);
    check("par_err_single", WIDTH'(parity_err), '0);
    check("par_no_overrun", WIDTH'(overrun), '0);
    bad_par = 1'b0;
    exp_q.push_back(32'h0A070011);
    send_bits(32'h0A070011, WIDTH, 1);
    end_frame();
    check("par_good_valid", WIDTH'(rx_valid), 1);
    check("par_good_err", WIDTH'(parity_err), '0);
    @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", WIDTH'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
